// File: rtl/conv_window_engine_if.sv
// Bus bundle for conv_window_engine: image-memory read port plus the
// valid/ready result stream with its output coordinates.
interface conv_window_engine_if #(
    parameter int AW = 5,
    parameter int OW = 8
);
    logic [AW-1:0] o_addr;
    logic          o_rd_en;
    logic          i_pixel;
    logic [OW-1:0] o_data;
    logic          o_valid;
    logic          i_ready;
    logic [7:0]    o_row;
    logic [7:0]    o_col;

    // Engine side: issues reads, presents results.
    modport master (
        output o_addr, o_rd_en, o_data, o_valid, o_row, o_col,
        input  i_pixel, i_ready
    );

    // Memory/consumer side: returns pixels, accepts results.
    modport slave (
        input  o_addr, o_rd_en, o_data, o_valid, o_row, o_col,
        output i_pixel, i_ready
    );
endinterface

// File: rtl/conv_window_engine.sv
// Time-multiplexed K x K convolution over a one-bit H x W image.
// One tap per cycle is fetched from image memory; each returned pixel
// gates a signed weight into the accumulator. Finished sums leave on a
// valid/ready stream tagged with their output row/column.
module conv_window_engine #(
    parameter int H  = 5,
    parameter int W  = 5,
    parameter int K  = 3,
    parameter int S  = 1,
    parameter int P  = 1,
    parameter int AW = 5,
    parameter int WW = 4,
    parameter int OW = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic [K*K*WW-1:0]    i_weights,
    output logic                 o_busy,
    output logic                 o_done,
    conv_window_engine_if.master bus
);
    localparam int OH   = (H + 2*P - K) / S + 1;
    localparam int OWC  = (W + 2*P - K) / S + 1;
    localparam int TAPS = K * K;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN,
        ST_OUT,
        ST_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    i_q, i_d;
    logic [7:0]    j_q, j_d;
    logic [7:0]    m_q, m_d;
    logic [7:0]    n_q, n_d;
    logic [OW-1:0] acc_q, acc_d;
    logic          tap_valid_q;
    logic [WW-1:0] tap_w_q;

    logic [WW-1:0] w_arr [TAPS];
    logic [WW-1:0] w_cur;
    logic [OW-1:0] contrib;
    logic          in_range;
    logic          rd_en;
    int            x_c;
    int            y_c;
    int            tap_c;

    // Unpack the flat kernel bus into one entry per tap.
    for (genvar gi = 0; gi < TAPS; gi++) begin : g_wunpack
        assign w_arr[gi] = i_weights[gi*WW +: WW];
    end

    // Decode the current tap: signed image coordinates, range check, weight.
    always_comb begin
        x_c      = int'(i_q) * S - P + int'(m_q);
        y_c      = int'(j_q) * S - P + int'(n_q);
        tap_c    = int'(m_q) * K + int'(n_q);
        in_range = (x_c >= 0) && (x_c < H) && (y_c >= 0) && (y_c < W);
        rd_en    = (state_q == ST_FETCH) && in_range;
        w_cur    = '0;
        for (int t = 0; t < TAPS; t++) begin
            if (tap_c == t) begin
                w_cur = w_arr[t];
            end
        end
    end

    // The pixel returned this cycle belongs to the tap registered last cycle;
    // padded taps never had a read, so they add nothing.
    always_comb begin
        contrib = '0;
        if (tap_valid_q && bus.i_pixel) begin
            contrib = {{(OW-WW){tap_w_q[WW-1]}}, tap_w_q};
        end
    end

    // Next-state logic for the scan FSM, counters and accumulator.
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        m_d     = m_q;
        n_d     = n_q;
        acc_d   = acc_q;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_FETCH;
                    i_d     = '0;
                    j_d     = '0;
                    m_d     = '0;
                    n_d     = '0;
                    acc_d   = '0;
                end
            end
            ST_FETCH: begin
                acc_d = acc_q + contrib;
                if (n_q == 8'(K-1)) begin
                    n_d = '0;
                    if (m_q == 8'(K-1)) begin
                        m_d     = '0;
                        state_d = ST_DRAIN;
                    end else begin
                        m_d = m_q + 8'd1;
                    end
                end else begin
                    n_d = n_q + 8'd1;
                end
            end
            ST_DRAIN: begin
                acc_d   = acc_q + contrib;
                state_d = ST_OUT;
            end
            ST_OUT: begin
                if (bus.i_ready) begin
                    acc_d = '0;
                    if (j_q == 8'(OWC-1)) begin
                        j_d = '0;
                        if (i_q == 8'(OH-1)) begin
                            i_d     = '0;
                            state_d = ST_DONE;
                        end else begin
                            i_d     = i_q + 8'd1;
                            state_d = ST_FETCH;
                        end
                    end else begin
                        j_d     = j_q + 8'd1;
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counter and accumulator registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            m_q     <= '0;
            n_q     <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            m_q     <= m_d;
            n_q     <= n_d;
            acc_q   <= acc_d;
        end
    end

    // Tap pipeline register aligning the weight with the next-cycle pixel.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tap_valid_q <= 1'b0;
            tap_w_q     <= '0;
        end else begin
            tap_valid_q <= rd_en;
            tap_w_q     <= w_cur;
        end
    end

    // Read port and result stream drive.
    always_comb begin
        bus.o_rd_en = rd_en;
        bus.o_addr  = rd_en ? AW'(x_c * W + y_c) : '0;
        bus.o_data  = acc_q;
        bus.o_valid = (state_q == ST_OUT);
        bus.o_row   = i_q;
        bus.o_col   = j_q;
        o_busy      = (state_q != ST_IDLE);
        o_done      = (state_q == ST_DONE);
    end
endmodule

// File: tb/tb_conv_window_engine.sv
// Bench for conv_window_engine: a registered one-bit image memory model,
// a direct sum-of-products reference and directed/random frames.
module tb_conv_window_engine;
    localparam int H   = 5;
    localparam int W   = 5;
    localparam int K   = 3;
    localparam int S   = 1;
    localparam int P   = 1;
    localparam int AW  = 5;
    localparam int WW  = 4;
    localparam int OW  = 8;
    localparam int OH  = (H + 2*P - K) / S + 1;
    localparam int OWC = (W + 2*P - K) / S + 1;
    localparam int NO  = OH * OWC;

    logic              clk;
    logic              rst;
    logic              start;
    logic [K*K*WW-1:0] weights;
    logic              busy;
    logic              done;

    conv_window_engine_if #(.AW(AW), .OW(OW)) bus ();

    conv_window_engine #(
        .H(H), .W(W), .K(K), .S(S), .P(P), .AW(AW), .WW(WW), .OW(OW)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_start   (start),
        .i_weights (weights),
        .o_busy    (busy),
        .o_done    (done),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    bit img [32];
    int wt  [K*K];

    // Image memory: data appears one cycle after the strobe; junk otherwise.
    always @(posedge clk) begin
        if (bus.o_rd_en) bus.i_pixel <= img[bus.o_addr];
        else             bus.i_pixel <= 1'($urandom);
    end

    int total = 0;
    int bad   = 0;

    logic signed [OW-1:0] out_data [NO];
    int out_row [NO];
    int out_col [NO];
    int nout, done_cnt, done_cyc, busy_after, first_valid;
    logic rd_log   [10];
    int   addr_log [10];

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int model(int oi, int oj);
        int s = 0;
        for (int m = 0; m < K; m++) begin
            for (int n = 0; n < K; n++) begin
                int x = oi * S - P + m;
                int y = oj * S - P + n;
                if (x >= 0 && x < H && y >= 0 && y < W && img[x*W + y])
                    s += wt[m*K + n];
            end
        end
        return s;
    endfunction

    task automatic load_weights();
        for (int t = 0; t < K*K; t++) weights[t*WW +: WW] = WW'(wt[t]);
    endtask

    task automatic random_data();
        for (int a = 0; a < 32; a++) img[a] = (a < H*W) ? 1'($urandom) : 1'b0;
        for (int t = 0; t < K*K; t++) wt[t] = $urandom_range(0, 15) - 8;
        load_weights();
    endtask

    // mode 0: ready high; mode 1: random ready; mode 2: 5-cycle stall at first OUT.
    task automatic run_frame(input int mode, input bit mid_start);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        nout = 0; done_cnt = 0; done_cyc = -1; busy_after = -1; first_valid = -1;
        for (int cyc = 1; cyc <= 3000; cyc++) begin
            if (cyc <= 9) begin
                rd_log[cyc]   = bus.o_rd_en;
                addr_log[cyc] = int'(bus.o_addr);
            end
            start = mid_start && (cyc == 3);
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc > 0 && cyc == done_cyc + 1) begin
                busy_after = int'(busy);
                break;
            end
            if (bus.o_valid && first_valid < 0) first_valid = cyc;
            if (mode == 1) begin
                bus.i_ready = ($urandom_range(0, 3) != 0);
            end else if (mode == 2 && cyc >= 11 && cyc <= 15) begin
                bus.i_ready = 1'b0;
                check($sformatf("stall_valid@%0d", cyc), bus.o_valid, 1);
                check($sformatf("stall_data@%0d", cyc), $signed(bus.o_data), model(0, 0));
                check($sformatf("stall_row@%0d", cyc), bus.o_row, 0);
                check($sformatf("stall_col@%0d", cyc), bus.o_col, 0);
                check($sformatf("stall_rd_en@%0d", cyc), bus.o_rd_en, 0);
            end else begin
                bus.i_ready = 1'b1;
            end
            if (mode == 2 && cyc == 17) begin
                check("resume_valid", bus.o_valid, 0);
                check("resume_busy", busy, 1);
            end
            if (bus.o_valid && bus.i_ready) begin
                if (nout < NO) begin
                    out_data[nout] = $signed(bus.o_data);
                    out_row[nout]  = int'(bus.o_row);
                    out_col[nout]  = int'(bus.o_col);
                end
                nout++;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        bus.i_ready = 1'b1;
        check("n_outputs", nout, NO);
        check("done_pulses", done_cnt, 1);
        check("busy_after_done", busy_after, 0);
        for (int k = 0; k < NO && k < nout; k++) begin
            check($sformatf("row[%0d]", k), out_row[k], k / OWC);
            check($sformatf("col[%0d]", k), out_col[k], k % OWC);
            check($sformatf("data(%0d,%0d)", k / OWC, k % OWC), out_data[k],
                  model(k / OWC, k % OWC));
        end
        if (mode == 0) begin
            check("first_valid_cycle", first_valid, K*K + 2);
            check("done_cycle", done_cyc, NO * (K*K + 2) + 1);
        end
        $display("frame mode=%0d outputs=%0d done_cycle=%0d", mode, nout, done_cyc);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; weights = '0; bus.i_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_addr", bus.o_addr, 0);
        check("rst_rd_en", bus.o_rd_en, 0);
        check("rst_data", bus.o_data, 0);
        check("rst_valid", bus.o_valid, 0);
        check("rst_row", bus.o_row, 0);
        check("rst_col", bus.o_col, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst = 1'b0;
        bus.i_ready = 1'b1;
        @(posedge clk); #1;
        check("idle_busy", busy, 0);

        // All ones / all +1, with a stray start pulse during FETCH.
        for (int a = 0; a < 32; a++) img[a] = (a < H*W);
        for (int t = 0; t < K*K; t++) wt[t] = 1;
        load_weights();
        run_frame(0, 1'b1);
        check("ones(0,0)", out_data[0], 4);
        check("ones(0,4)", out_data[4], 4);
        check("ones(4,0)", out_data[20], 4);
        check("ones(4,4)", out_data[24], 4);
        check("ones(0,2)", out_data[2], 6);
        check("ones(2,0)", out_data[10], 6);
        check("ones(2,2)", out_data[12], 9);
        // Window (0,0): only taps 4,5,7,8 fall inside the image.
        for (int c = 1; c <= 9; c++) begin
            int exp_addr;
            exp_addr = (c == 5) ? 0 : (c == 6) ? 1 : (c == 8) ? 5 : (c == 9) ? 6 : 0;
            check($sformatf("win00_rd_en@%0d", c), rd_log[c],
                  (c == 5 || c == 6 || c == 8 || c == 9) ? 1 : 0);
            check($sformatf("win00_addr@%0d", c), addr_log[c], exp_addr);
        end

        // Single set pixel at (2,2), weight t-4.
        for (int a = 0; a < 32; a++) img[a] = (a == 2*W + 2);
        for (int t = 0; t < K*K; t++) wt[t] = t - 4;
        load_weights();
        run_frame(0, 1'b0);
        check("one(1,1)", out_data[1*OWC + 1], 4);
        check("one(3,3)", out_data[3*OWC + 3], -4);
        check("one(2,2)", out_data[2*OWC + 2], 0);
        check("one(1,3)", out_data[1*OWC + 3], 2);
        check("one(0,0)", out_data[0], 0);
        check("one(4,2)", out_data[4*OWC + 2], 0);

        // Stall at first OUT on random data.
        random_data();
        run_frame(2, 1'b0);

        // Random images and weights with random back-pressure.
        for (int r = 0; r < 3; r++) begin
            random_data();
            run_frame(1, 1'b0);
        end

        // Reset in the middle of a frame, then a clean restart.
        random_data();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (29) begin
            @(posedge clk); #1;
        end
        check("pre_rst_busy", busy, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("post_rst_busy", busy, 0);
        check("post_rst_valid", bus.o_valid, 0);
        check("post_rst_rd_en", bus.o_rd_en, 0);
        check("post_rst_done", done, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        run_frame(0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
